// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the ALU operand/opcode sequencer.
//                Holds the state encoding, the control-flag bundle and the
//                Moore decode from state to control flags.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle = 3'd0;
    localparam logic [c_state_w-1:0] c_st_clr  = 3'd1;
    localparam logic [c_state_w-1:0] c_st_lda  = 3'd2;
    localparam logic [c_state_w-1:0] c_st_ldb  = 3'd3;
    localparam logic [c_state_w-1:0] c_st_ldop = 3'd4;
    localparam logic [c_state_w-1:0] c_st_exec = 3'd5;
    localparam logic [c_state_w-1:0] c_st_rd   = 3'd6;
    localparam logic [c_state_w-1:0] c_st_done = 3'd7;

    typedef enum logic [c_state_w-1:0] {
        S_IDLE = c_st_idle,
        S_CLR  = c_st_clr,
        S_LDA  = c_st_lda,
        S_LDB  = c_st_ldb,
        S_LDOP = c_st_ldop,
        S_EXEC = c_st_exec,
        S_RD   = c_st_rd,
        S_DONE = c_st_done
    } state_t;

    // Single-bit control outputs, all Moore functions of the state.
    typedef struct packed {
        logic ready;
        logic bus_oe;
        logic rs1;
        logic rs2;
        logic rs3;
        logic lrst;
        logic alu_oe;
        logic done;
    } ctrl_t;

    // Value the control flags take while the sequencer sits in state s.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE: c.ready  = 1'b1;
            S_CLR:  c.lrst   = 1'b1;
            S_LDA: begin
                c.bus_oe = 1'b1;
                c.rs1    = 1'b1;
            end
            S_LDB: begin
                c.bus_oe = 1'b1;
                c.rs2    = 1'b1;
            end
            S_LDOP: begin
                c.bus_oe = 1'b1;
                c.rs3    = 1'b1;
            end
            S_RD:   c.alu_oe = 1'b1;
            S_DONE: c.done   = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Sequencer for the ALU operand/opcode register bank. Per
//                accepted start it drives A, B and the opcode onto the shared
//                bus with the matching load strobe, waits EXEC_CYC settle
//                cycles, enables the ALU onto the bus and captures the result.
//                All control outputs are registered so they change cleanly
//                on the clock edge that enters each state.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int W        = 4,
    parameter int EXEC_CYC = 1
) (
    input  logic         clk,
    input  logic         grst,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] op_in,
    input  logic [W-1:0] bus_in,
    output logic         ready,
    output logic [W-1:0] bus_out,
    output logic         bus_oe,
    output logic         rs1,
    output logic         rs2,
    output logic         rs3,
    output logic         lrst,
    output logic         alu_oe,
    output logic [W-1:0] result,
    output logic         done
);

    localparam int                 c_cnt_w    = $clog2(EXEC_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(EXEC_CYC - 1);

    // Reset value of the control flags: idle, ready, nothing driven.
    localparam ctrl_t c_ctrl_rst = '{ready: 1'b1, default: 1'b0};

    state_t         r_state;
    state_t         w_next;
    ctrl_t          r_ctrl;
    logic [W-1:0]   r_bus;
    logic [W-1:0]   w_bus_nxt;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_op;
    logic [W-1:0]   r_result;
    logic [c_cnt_w-1:0] r_cnt;

    // State register.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the bus value for the state being entered.
    // Operand A goes straight from a_in into the bus register on the
    // accepting edge, so only B and the opcode need their own latches.
    always_comb begin
        w_next    = r_state;
        w_bus_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_next = S_CLR;
                end else if (start) begin
                    w_next = S_LDA;
                end
            end
            S_CLR:  w_next = S_IDLE;
            S_LDA:  w_next = S_LDB;
            S_LDB:  w_next = S_LDOP;
            S_LDOP: w_next = S_EXEC;
            S_EXEC: begin
                if (r_cnt == c_cnt_last) begin
                    w_next = S_RD;
                end
            end
            S_RD:   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        case (w_next)
            S_LDA:  w_bus_nxt = a_in;
            S_LDB:  w_bus_nxt = r_b;
            S_LDOP: w_bus_nxt = r_op;
            default: w_bus_nxt = '0;
        endcase
    end

    // Registered Moore outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_ctrl <= c_ctrl_rst;
            r_bus  <= '0;
        end else begin
            r_ctrl <= decode_ctrl(w_next);
            r_bus  <= w_bus_nxt;
        end
    end

    // Operand latches: captured only on the edge that accepts a start.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_b  <= '0;
            r_op <= '0;
        end else if (r_state == S_IDLE && !clr && start) begin
            r_b  <= b_in;
            r_op <= op_in;
        end
    end

    // Settle counter: runs only while in EXEC, parked at zero otherwise.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Result capture at the end of the ALU read cycle; held otherwise.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_result <= '0;
        end else if (r_state == S_RD) begin
            r_result <= bus_in;
        end
    end

    assign ready   = r_ctrl.ready;
    assign bus_oe  = r_ctrl.bus_oe;
    assign rs1     = r_ctrl.rs1;
    assign rs2     = r_ctrl.rs2;
    assign rs3     = r_ctrl.rs3;
    assign lrst    = r_ctrl.lrst;
    assign alu_oe  = r_ctrl.alu_oe;
    assign done    = r_ctrl.done;
    assign bus_out = r_bus;
    assign result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Self-checking bench for alu_seq_ctrl. Two instances
//                (EXEC_CYC = 1 and 3) share clock and reset. A bench-side
//                ALU register bank answers the bus; a cycle-schedule model
//                predicts every control output, and a result scoreboard is
//                filled at acceptance and drained on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int W    = 4;
    localparam int NDUT = 2;

    typedef struct {
        logic [W-1:0] res;
        int           done_at;
    } exp_t;

    logic         clk = 1'b0;
    logic         grst;
    logic         start  [NDUT];
    logic         clr    [NDUT];
    logic [W-1:0] a_in   [NDUT];
    logic [W-1:0] b_in   [NDUT];
    logic [W-1:0] op_in  [NDUT];
    logic [W-1:0] bus_in [NDUT];
    logic [W-1:0] noise  [NDUT];
    logic         ready  [NDUT];
    logic [W-1:0] bus_out[NDUT];
    logic         bus_oe [NDUT];
    logic         rs1    [NDUT];
    logic         rs2    [NDUT];
    logic         rs3    [NDUT];
    logic         lrst   [NDUT];
    logic         alu_oe [NDUT];
    logic [W-1:0] result [NDUT];
    logic         done   [NDUT];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model state: what was last accepted and when (kind 0 none, 1 op, 2 clr).
    int           kind    [NDUT];
    int           acc_e   [NDUT];
    logic [W-1:0] la      [NDUT];
    logic [W-1:0] exp_res [NDUT];
    logic         prev_aoe[NDUT];
    int           n_rs    [NDUT];
    int           n_lrst  [NDUT];
    int           x_rs    [NDUT];
    int           x_lrst  [NDUT];
    exp_t         sb0[$];
    exp_t         sb1[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int ec(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference ALU the bench uses both to answer RD and to predict result.
    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b, op);
        logic [W-1:0] r;
        case (op[1:0])
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: r = a ^ b;
            default: r = a | b;
        endcase
        return op[3] ? ~r : r;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [W-1:0] ra, rb, rop;

        alu_seq_ctrl #(.W(W), .EXEC_CYC((g == 0) ? 1 : 3)) u_dut (
            .clk    (clk),
            .grst   (grst),
            .start  (start[g]),
            .clr    (clr[g]),
            .a_in   (a_in[g]),
            .b_in   (b_in[g]),
            .op_in  (op_in[g]),
            .bus_in (bus_in[g]),
            .ready  (ready[g]),
            .bus_out(bus_out[g]),
            .bus_oe (bus_oe[g]),
            .rs1    (rs1[g]),
            .rs2    (rs2[g]),
            .rs3    (rs3[g]),
            .lrst   (lrst[g]),
            .alu_oe (alu_oe[g]),
            .result (result[g]),
            .done   (done[g])
        );

        // ALU register bank loading off the bus.
        always @(posedge clk) begin
            if (rs1[g]) ra <= bus_out[g];
            if (rs2[g]) rb <= bus_out[g];
            if (rs3[g]) rop <= bus_out[g];
        end

        assign bus_in[g] = alu_oe[g] ? alu_f(ra, rb, rop) : noise[g];
    end

    function automatic logic mready(input int i, input int n);
        if (kind[i] == 1) return (n - acc_e[i]) >= 6 + ec(i);
        if (kind[i] == 2) return (n - acc_e[i]) >= 2;
        return 1'b1;
    endfunction

    // Drive one instance for the coming edge and record what the model accepts.
    task automatic drive(input int i, input logic s, input logic c,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
        exp_t e;
        start[i] = s;
        clr[i]   = c;
        a_in[i]  = a;
        b_in[i]  = b;
        op_in[i] = op;
        if (!grst && mready(i, edge_n)) begin
            if (c) begin
                kind[i]   = 2;
                acc_e[i]  = edge_n;
                x_lrst[i] = x_lrst[i] + 1;
            end else if (s) begin
                kind[i]  = 1;
                acc_e[i] = edge_n;
                la[i]    = a;
                x_rs[i]  = x_rs[i] + 3;
                e.res     = alu_f(a, b, op);
                e.done_at = edge_n + 5 + ec(i);
                if (i == 0) sb0.push_back(e); else sb1.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) noise[i] = W'($urandom);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NDUT; i++) drive(i, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_ready();
        for (int t = 0; t < 40 && !(mready(0, edge_n) && mready(1, edge_n)); t++) begin
            tick();
            idle_all();
        end
    endtask

    // Monitor: per-cycle output schedule, invariants and result scoreboard.
    always @(negedge clk) begin
        logic [7:0]   xv, av;
        logic [W-1:0] xbo;
        exp_t         e;
        int           k;
        logic         have;
        for (int i = 0; i < NDUT; i++) begin
            k   = edge_n - acc_e[i];
            xv  = 8'b1000_0000;
            xbo = '0;
            if (kind[i] == 1) begin
                xv = {(k >= 6 + ec(i)), 7'b0};
                if (k == 1) begin xv[6] = 1'b1; xv[5] = 1'b1; xbo = la[i]; end
                if (k == 2) begin xv[6] = 1'b1; xv[4] = 1'b1; xbo = b_in_lat(i); end
                if (k == 3) begin xv[6] = 1'b1; xv[3] = 1'b1; xbo = op_lat(i); end
                if (k == 4 + ec(i)) xv[1] = 1'b1;
                if (k == 5 + ec(i)) xv[0] = 1'b1;
            end else if (kind[i] == 2) begin
                xv = {(k >= 2), 7'b0};
                if (k == 1) xv[2] = 1'b1;
            end
            av = {ready[i], bus_oe[i], rs1[i], rs2[i], rs3[i], lrst[i], alu_oe[i], done[i]};
            checks++;
            if (av !== xv || bus_out[i] !== xbo) begin
                errors++;
                $display("FAIL outputs dut%0d edge %0d: got flags=%b bus=%h, want flags=%b bus=%h",
                         i, edge_n, av, bus_out[i], xv, xbo);
            end
            checks++;
            if ((32'(rs1[i]) + 32'(rs2[i]) + 32'(rs3[i]) + 32'(lrst[i])) > 1 || (bus_oe[i] && alu_oe[i])) begin
                errors++;
                $display("FAIL exclusive dut%0d edge %0d: got rs=%b%b%b lrst=%b oe=%b aoe=%b, want at most one strobe and one driver",
                         i, edge_n, rs1[i], rs2[i], rs3[i], lrst[i], bus_oe[i], alu_oe[i]);
            end
            if (done[i]) begin
                checks++;
                if (!prev_aoe[i]) begin
                    errors++;
                    $display("FAIL done_after_rd dut%0d edge %0d: got done without preceding RD, want RD first", i, edge_n);
                end
                have = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL sb_empty dut%0d edge %0d: got done, want no done", i, edge_n);
                end else begin
                    e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    exp_res[i] = e.res;
                    checks++;
                    if (e.done_at != edge_n) begin
                        errors++;
                        $display("FAIL done_time dut%0d: got edge %0d, want edge %0d", i, edge_n, e.done_at);
                    end
                end
            end
            checks++;
            if (result[i] !== exp_res[i]) begin
                errors++;
                $display("FAIL result dut%0d edge %0d: got %h, want %h", i, edge_n, result[i], exp_res[i]);
            end
            n_rs[i]     = n_rs[i] + 32'(rs1[i]) + 32'(rs2[i]) + 32'(rs3[i]);
            n_lrst[i]   = n_lrst[i] + 32'(lrst[i]);
            prev_aoe[i] = alu_oe[i];
        end
    end

    // B and opcode as latched at acceptance, kept beside A in the model.
    logic [W-1:0] lb [NDUT];
    logic [W-1:0] lop[NDUT];
    function automatic logic [W-1:0] b_in_lat(input int i); return lb[i]; endfunction
    function automatic logic [W-1:0] op_lat(input int i);   return lop[i]; endfunction
    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (kind[i] == 1 && acc_e[i] == edge_n) begin
                lb[i]  <= b_in[i];
                lop[i] <= op_in[i];
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            kind[i]    = 0;
            acc_e[i]   = 0;
            exp_res[i] = '0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, op;
        grst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            start[i] = 0; clr[i] = 0; a_in[i] = '0; b_in[i] = '0; op_in[i] = '0; noise[i] = '0;
            n_rs[i] = 0; n_lrst[i] = 0; x_rs[i] = 0; x_lrst[i] = 0; prev_aoe[i] = 0;
            la[i] = '0;
        end
        model_reset();
        repeat (3) tick();
        grst = 1'b0;
        tick();

        // Basic op A=3,B=5,OP=2 with start held; busy retries carry A=F and
        // the first IDLE after DONE takes the new operands 9,4,0.
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (c == 0)     drive(i, 1'b1, 1'b0, 4'h3, 4'h5, 4'h2);
                else if (c < 6) drive(i, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
                else            drive(i, 1'b1, 1'b0, 4'h9, 4'h4, 4'h0);
            end
            tick();
        end
        idle_all();
        wait_ready();

        // start and clr together in IDLE: clear wins, no load strobes.
        tick();
        for (int i = 0; i < NDUT; i++) drive(i, 1'b1, 1'b1, 4'h7, 4'h7, 4'h7);
        tick();
        idle_all();
        repeat (4) tick();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                a = W'($urandom); b = W'($urandom); op = W'($urandom);
                drive(i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), a, b, op);
            end
        end
        tick();
        idle_all();
        wait_ready();

        // grst asserted while both instances are in LDB.
        tick();
        for (int i = 0; i < NDUT; i++) drive(i, 1'b1, 1'b0, 4'hC, 4'h6, 4'h1);
        tick();
        idle_all();
        tick();
        grst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({ready[i], bus_oe[i], rs1[i], rs2[i], rs3[i], lrst[i], alu_oe[i], done[i]} !== 8'b1000_0000
                || bus_out[i] !== '0 || result[i] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got flags=%b bus=%h result=%h, want flags=10000000 bus=0 result=0",
                         i, {ready[i], bus_oe[i], rs1[i], rs2[i], rs3[i], lrst[i], alu_oe[i], done[i]},
                         bus_out[i], result[i]);
            end
        end
        repeat (2) tick();
        grst = 1'b0;
        repeat (10) tick();

        // Recovery op after reset.
        for (int i = 0; i < NDUT; i++) drive(i, 1'b1, 1'b0, 4'h3, 4'h5, 4'h2);
        tick();
        idle_all();
        wait_ready();
        repeat (2) tick();

        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (((i == 0) ? sb0.size() : sb1.size()) != 0) begin
                errors++;
                $display("FAIL sb_drain dut%0d: got %0d pending, want 0", i, (i == 0) ? sb0.size() : sb1.size());
            end
            checks++;
            if (n_lrst[i] != x_lrst[i]) begin
                errors++;
                $display("FAIL lrst_count dut%0d: got %0d, want %0d", i, n_lrst[i], x_lrst[i]);
            end
        end
        // Strobe totals span the reset, so the aborted op contributed rs1+rs2 only.
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (n_rs[i] != x_rs[i] - 1) begin
                errors++;
                $display("FAIL rs_count dut%0d: got %0d, want %0d", i, n_rs[i], x_rs[i] - 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
